data_write_buffer: RTL and testbench



---
 rtl/data_write_buffer.sv | 178 +++++++++++++++++
 tb/tb_data_write_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : data_write_buffer
// Purpose  : Posted-write buffer between the CPU data-side SRAM-like port and
//            the bridge's data port. Stores are acknowledged one cycle after
//            acceptance and drained in order, one downstream transaction at a
//            time. Loads are only accepted once the buffer has fully drained,
//            so CPU response order and memory order are both preserved.
// Ports    : clk, resetn            - clock, asynchronous active-low reset
//            cpu_req/wr/size/addr/wdata -> request from CPU
//            cpu_addr_ok/data_ok/rdata  <- handshake/response to CPU
//            mem_req/wr/size/addr/wdata <- request to bridge
//            mem_addr_ok/data_ok/rdata  -> handshake/response from bridge
//            wb_empty               - FIFO empty and no transaction in flight
// Revision : 1.0 - initial release
// ============================================================================
module data_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [1:0]    cpu_size,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_addr_ok,
  output logic          cpu_data_ok,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  output logic          wb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4
  } state_t;

  state_t        state_q, state_d;

  logic [1:0]    fifo_size_q  [DEPTH];
  logic [AW-1:0] fifo_addr_q  [DEPTH];
  logic [DW-1:0] fifo_wdata_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          wr_ack_q;
  logic [1:0]    rd_size_q;
  logic [AW-1:0] rd_addr_q;

  logic w_empty, w_full, w_rd_busy;
  logic w_store_ok, w_load_ok;
  logic w_push, w_pop, w_load_acc;

  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == CW'(DEPTH));
  assign w_rd_busy  = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);

  // Acceptance depends only on registered state: a pop in this cycle does not
  // make room for a push in the same cycle.
  assign w_store_ok = !w_full && !w_rd_busy;
  assign w_load_ok  = w_empty && (state_q == S_IDLE);

  assign cpu_addr_ok = cpu_req && (cpu_wr ? w_store_ok : w_load_ok);

  assign w_push     = cpu_req && cpu_wr && w_store_ok;
  assign w_load_acc = cpu_req && !cpu_wr && w_load_ok;
  assign w_pop      = (state_q == S_WR_REQ) && mem_addr_ok;

  assign wb_empty   = w_empty && (state_q == S_IDLE);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // A load is only accepted while empty, so these never compete.
        if (w_load_acc)    state_d = S_RD_REQ;
        else if (!w_empty) state_d = S_WR_REQ;
      end
      S_WR_REQ:  if (mem_addr_ok) state_d = S_WR_WAIT;
      S_WR_WAIT: if (mem_data_ok) state_d = S_IDLE;
      S_RD_REQ:  if (mem_addr_ok) state_d = S_RD_WAIT;
      S_RD_WAIT: if (mem_data_ok) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Downstream request and CPU response decode. Request fields come straight
  // from registers, so they hold steady while the bridge stalls.
  always_comb begin
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_size    = 2'd0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_rdata   = '0;
    cpu_data_ok = wr_ack_q;
    case (state_q)
      S_WR_REQ: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_size  = fifo_size_q[head_q];
        mem_addr  = fifo_addr_q[head_q];
        mem_wdata = fifo_wdata_q[head_q];
      end
      S_RD_REQ: begin
        mem_req  = 1'b1;
        mem_size = rd_size_q;
        mem_addr = rd_addr_q;
      end
      S_RD_WAIT: begin
        // Load data is forwarded in the same cycle the bridge returns it.
        if (mem_data_ok) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_ack_q  <= 1'b0;
      rd_size_q <= 2'd0;
      rd_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_size_q[i]  <= 2'd0;
        fifo_addr_q[i]  <= '0;
        fifo_wdata_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      // Store ack is a one-cycle pulse following each accepted store.
      wr_ack_q <= w_push;

      if (w_push) begin
        fifo_size_q[tail_q]  <= cpu_size;
        fifo_addr_q[tail_q]  <= cpu_addr;
        fifo_wdata_q[tail_q] <= cpu_wdata;
        tail_q               <= tail_q + 1'b1;
      end
      if (w_pop) head_q <= head_q + 1'b1;

      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase

      if (w_load_acc) begin
        rd_size_q <= cpu_size;
        rd_addr_q <= cpu_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_write_buffer
// Purpose  : Randomised self-checking bench for data_write_buffer. A reference
//            model tracks pending stores as a queue, the in-flight downstream
//            transaction as flags, and CPU-visible / bridge-visible memory as
//            associative arrays; a behavioural bridge responds with random
//            handshake delays and occasional stray responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cpu_req, cpu_wr;
  logic [1:0]    cpu_size;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_addr_ok, cpu_data_ok;
  logic          mem_req, mem_wr;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_addr_ok, mem_data_ok;
  logic          wb_empty;

  always #5 clk = ~clk;

  data_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .wb_empty(wb_empty)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        wq[$];                 // stores accepted but not yet handed downstream
  logic [31:0] cpu_mem [logic [31:0]]; // memory as the CPU expects to see it
  logic [31:0] slv_mem [logic [31:0]]; // memory as the bridge has received it
  bit          wr_out, rd_active, rd_issued, ack_pend;
  logic [1:0]  rd_size;
  logic [31:0] rd_addr;
  int          gap;

  // behavioural bridge
  bit          s_out, s_is_rd;
  int          s_lat;
  logic [31:0] s_addr;

  // CPU driver
  bit          hold;
  int          p_req, p_aok;

  function automatic logic [31:0] cpu_lookup(input logic [31:0] a);
    return cpu_mem.exists(a) ? cpu_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] slv_lookup(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data_ok"}, cpu_data_ok, 0);
    check_eq({tag, "_mem_req"}, mem_req, 0);
    check_eq({tag, "_wb_empty"}, wb_empty, 1);
    check_eq({tag, "_mem_fields"}, {mem_wr, mem_size, mem_addr}, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "_rdata"}, cpu_rdata, 0);
  endtask

  task automatic clear_model();
    wq.delete();
    wr_out = 0; rd_active = 0; rd_issued = 0; ack_pend = 0;
    s_out = 0; hold = 0; gap = 0;
    // Stores still in the buffer are lost; the CPU view falls back to memory.
    cpu_mem.delete();
    foreach (slv_mem[k]) cpu_mem[k] = slv_mem[k];
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    cpu_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    #1;
    check_reset_outputs("midrst");
    clear_model();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic step();
    bit   exp_aok, rsp_now, rd_done, do_issue, ack_n;
    @(negedge clk);

    // bridge side
    mem_data_ok = 1'b0;
    mem_rdata   = $urandom;
    if (s_out) begin
      if (s_lat == 0) begin
        mem_data_ok = 1'b1;
        if (s_is_rd) mem_rdata = slv_lookup(s_addr);
      end
    end else begin
      mem_data_ok = ($urandom_range(0, 7) == 0); // stray response, must be ignored
    end
    mem_addr_ok = ($urandom_range(0, 99) < p_aok);

    // CPU side: a request is held until accepted
    if (!hold && ($urandom_range(0, 99) < p_req)) begin
      hold      = 1;
      cpu_wr    = ($urandom_range(0, 99) < 70);
      cpu_size  = 2'($urandom_range(0, 2));
      cpu_addr  = 32'($urandom_range(0, 15)) << 2;
      cpu_wdata = $urandom;
    end
    cpu_req = hold;
    #1;

    exp_aok = hold && (cpu_wr ? (wq.size() < DEPTH && !rd_active)
                              : (wq.size() == 0 && !wr_out && !rd_active));
    check_eq("addr_ok", cpu_addr_ok, exp_aok);

    rsp_now = s_out && (s_lat == 0);
    rd_done = rsp_now && s_is_rd;
    check_eq("data_ok", cpu_data_ok, ack_pend || rd_done);
    if (rd_done) check_eq("rdata", cpu_rdata, cpu_lookup(rd_addr));
    check_eq("wb_empty", wb_empty, wq.size() == 0 && !wr_out && !rd_active);

    do_issue = 0;
    if (wr_out || rd_issued) begin
      check_eq("mem_req_in_wait", mem_req, 0);
      gap = 0;
    end else if (mem_req) begin
      gap = 0;
      if (rd_active) begin
        check_eq("rd_fields", {mem_wr, mem_size, mem_addr}, {1'b0, rd_size, rd_addr});
        check_eq("rd_wdata", mem_wdata, 0);
      end else if (wq.size() == 0) begin
        check_eq("mem_req_idle", mem_req, 0);
      end else begin
        check_eq("wr_fields", {mem_wr, mem_size, mem_addr}, {1'b1, wq[0].size, wq[0].addr});
        check_eq("wr_wdata", mem_wdata, wq[0].data);
      end
      do_issue = mem_addr_ok && (rd_active || wq.size() != 0);
    end else if (rd_active || wq.size() != 0) begin
      gap++;
      if (gap > 1) check_eq("mem_req_late", mem_req, 1);
    end else begin
      gap = 0;
    end

    // response retires the outstanding transaction
    if (rsp_now) begin
      s_out = 0;
      if (s_is_rd) begin rd_active = 0; rd_issued = 0; end
      else wr_out = 0;
    end else if (s_out) begin
      s_lat--;
    end

    if (do_issue) begin
      s_out = 1;
      s_lat = $urandom_range(0, 3);
      if (rd_active) begin
        rd_issued = 1; s_is_rd = 1; s_addr = rd_addr;
      end else begin
        ent_t e;
        e = wq.pop_front();
        slv_mem[e.addr] = e.data;
        wr_out = 1; s_is_rd = 0; s_addr = e.addr;
      end
    end

    ack_n = 0;
    if (exp_aok) begin
      if (cpu_wr) begin
        ent_t e;
        e.size = cpu_size; e.addr = cpu_addr; e.data = cpu_wdata;
        wq.push_back(e);
        cpu_mem[cpu_addr] = cpu_wdata;
        ack_n = 1;
      end else begin
        rd_active = 1; rd_size = cpu_size; rd_addr = cpu_addr;
      end
    end
    if (cpu_addr_ok) hold = 0;
    ack_pend = ack_n;
  endtask

  initial begin
    resetn = 1'b1;
    cpu_req = 0; cpu_wr = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    clear_model();
    #2 resetn = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // general random traffic
    p_req = 60; p_aok = 70;
    repeat (600) step();

    // stalled bridge: buffer fills and stores must be refused when full
    p_req = 95; p_aok = 0;
    repeat (30) step();
    p_aok = 100;
    repeat (100) step();

    // resets in the middle of draining
    for (int r = 0; r < 6; r++) begin
      p_req = 90; p_aok = 0;
      repeat (12) step();
      p_aok = 50;
      repeat (3) step();
      do_reset();
      p_req = 50; p_aok = 60;
      repeat (150) step();
    end

    // slow bridge, sparse requests
    p_req = 30; p_aok = 20;
    repeat (400) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
